// File: rtl/fetch_mem_if.sv
// Instruction-fetch memory interface: issues one outstanding imem read per accepted PC,
// queues {pc, inst} pairs toward decode and squashes wrong-path responses on redirect.
module fetch_mem_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] pc_in,
  input  logic              redirect,
  output logic              fetch_stall,
  output logic              imem_req_valid,
  output logic [DWIDTH-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [DWIDTH-1:0] imem_resp_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [DWIDTH-1:0] dec_inst,
  output logic [DWIDTH-1:0] dec_pc
);

  localparam int unsigned   CW    = $clog2(QDEPTH + 1);
  localparam int unsigned   PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [CW-1:0] CMAX  = CW'(QDEPTH);
  localparam logic [PW-1:0] PLAST = PW'(QDEPTH - 1);

  typedef enum logic {StReq, StWait} state_e;

  state_e            r_state;
  logic [CW-1:0]     r_count;
  logic              r_squash;
  logic [DWIDTH-1:0] r_pend_pc;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [DWIDTH-1:0] r_pc_mem   [QDEPTH];
  logic [DWIDTH-1:0] r_inst_mem [QDEPTH];

  logic w_accept;
  logic w_push;
  logic w_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PLAST) ? '0 : p + 1'b1;
  endfunction

  // Outputs are forced to their idle values while rst is held, not just after it.
  assign imem_req_valid = !rst && (r_state == StReq) && (r_count < CMAX) && !redirect;
  assign imem_req_addr  = pc_in;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign fetch_stall    = rst || (!w_accept && !redirect);

  assign w_push    = (r_state == StWait) && imem_resp_valid && !r_squash && !redirect;
  assign dec_valid = (r_count != '0);
  assign w_pop     = dec_valid && dec_ready;
  assign dec_pc    = r_pc_mem[r_head];
  assign dec_inst  = r_inst_mem[r_head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StReq;
      r_squash  <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      unique case (r_state)
        StReq: begin
          if (w_accept) begin
            r_pend_pc <= pc_in;
            r_state   <= StWait;
          end
        end
        StWait: begin
          // A response landing with the redirect is simply dropped; no squash residue.
          if (imem_resp_valid) begin
            r_squash <= 1'b0;
            r_state  <= StReq;
          end else if (redirect) begin
            r_squash <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (redirect) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      if (w_push) r_tail <= ptr_next(r_tail);
      if (w_pop)  r_head <= ptr_next(r_head);
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]   <= r_pend_pc;
      r_inst_mem[r_tail] <= imem_resp_data;
    end
  end

  // Issue is gated on count < QDEPTH, so a push into a full queue means broken gating.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && (r_count == CMAX)));
    end
  end

endmodule
